// File: rtl/vector_element_sequencer.sv
// Steps one decoded vector (or scalar) instruction across register-file elements, one element per cycle.
// Optional feature: define VECTOR_MASK_EN to add v0_mask predication and the elem_we output.
module vector_element_sequencer #(
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        chip_enabled,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic                        is_vector_instruction,
  input  logic [ENTRY_INDEX_SIZE:0]   vl,
  input  logic [2:0]                  alu_signal,
  input  logic [1:0]                  mem_vis_signal,
  input  logic [1:0]                  wb_signal,
  input  logic [4:0]                  d_index,
  input  logic                        elem_ready,
  input  logic                        mem_done,
  output logic                        elem_valid,
  output logic [ENTRY_INDEX_SIZE-1:0] elem_index,
  output logic                        elem_last,
  output logic [2:0]                  op_alu,
  output logic [1:0]                  op_mem,
  output logic [1:0]                  op_wb,
  output logic [4:0]                  op_d,
`ifdef VECTOR_MASK_EN
  input  logic [VECTOR_SIZE-1:0]      v0_mask,
  output logic                        elem_we,
`endif
  output logic                        done
);

  localparam int CW = ENTRY_INDEX_SIZE + 1;
  localparam logic [CW-1:0] VS_C = CW'(VECTOR_SIZE);

  typedef enum logic [1:0] {IDLE, EXEC, MEM_WAIT, COMMIT} state_t;

  state_t                      state_q, state_d;
  logic [ENTRY_INDEX_SIZE-1:0] idx_q, idx_d;
  logic [CW-1:0]               n_q, n_d;
  logic                        is_vec_q, is_vec_d;
  logic [VECTOR_SIZE-1:0]      mask_q, mask_d;
  logic [2:0]                  alu_q, alu_d;
  logic [1:0]                  mem_q, mem_d;
  logic [1:0]                  wb_q, wb_d;
  logic [4:0]                  d_q, d_d;
  logic                        valid_q, last_q, done_q, ready_q, we_q;
  logic                        valid_d, last_d, done_d, ready_d, we_d;
  logic                        last_cur, en_cur;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    n_d      = n_q;
    is_vec_d = is_vec_q;
    mask_d   = mask_q;
    alu_d    = alu_q;
    mem_d    = mem_q;
    wb_d     = wb_q;
    d_d      = d_q;
    last_cur = ({1'b0, idx_q} == (n_q - CW'(1)));
    en_cur   = is_vec_q ? mask_q[idx_q] : 1'b1;

    case (state_q)
      IDLE: begin
        if (issue_valid) begin
          is_vec_d = is_vector_instruction;
`ifdef VECTOR_MASK_EN
          mask_d   = v0_mask;
`else
          mask_d   = '1;
`endif
          alu_d    = alu_signal;
          mem_d    = mem_vis_signal;
          wb_d     = wb_signal;
          d_d      = d_index;
          n_d      = is_vector_instruction ? ((vl > VS_C) ? VS_C : vl) : CW'(1);
          idx_d    = '0;
          state_d  = (n_d == '0) ? COMMIT : EXEC;
        end
      end
      EXEC: begin
        // masked-off elements never touch memory, so they step like ALU elements
        if (elem_ready) begin
          if (mem_q != '0 && en_cur) state_d = MEM_WAIT;
          else if (last_cur)         state_d = COMMIT;
          else                       idx_d   = idx_q + ENTRY_INDEX_SIZE'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_done) begin
          if (last_cur) state_d = COMMIT;
          else begin
            idx_d   = idx_q + ENTRY_INDEX_SIZE'(1);
            state_d = EXEC;
          end
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == EXEC);
    ready_d = (state_d == IDLE);
    done_d  = (state_d == COMMIT);
    last_d  = (state_d == EXEC) && ({1'b0, idx_d} == (n_d - CW'(1)));
    we_d    = is_vec_d ? mask_d[idx_d] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      n_q      <= '0;
      is_vec_q <= 1'b0;
      mask_q   <= '0;
      alu_q    <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      d_q      <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      we_q     <= 1'b0;
    end else if (chip_enabled) begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      is_vec_q <= is_vec_d;
      mask_q   <= mask_d;
      alu_q    <= alu_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      d_q      <= d_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
    end
  end

  assign issue_ready = ready_q & chip_enabled;
  assign elem_valid  = valid_q & chip_enabled;
  assign done        = done_q & chip_enabled;
  assign elem_last   = last_q;
  assign elem_index  = idx_q;
  assign op_alu      = alu_q;
  assign op_mem      = mem_q;
  assign op_wb       = wb_q;
  assign op_d        = d_q;
`ifdef VECTOR_MASK_EN
  assign elem_we     = we_q;
`else
  logic unused_we;
  assign unused_we   = we_q;
`endif

endmodule

// File: tb/tb_vector_element_sequencer.sv
// Randomised self-checking bench for vector_element_sequencer; mask checks active when VECTOR_MASK_EN is defined.
module tb_vector_element_sequencer;
  localparam int VS = 8;
  localparam int EW = 3;

  logic          clk = 1'b0;
  logic          rst_n, chip_enabled, issue_valid, is_vector_instruction;
  logic [EW:0]   vl;
  logic [2:0]    alu_signal;
  logic [1:0]    mem_vis_signal, wb_signal;
  logic [4:0]    d_index;
  logic          elem_ready, mem_done;
  logic          issue_ready, elem_valid, elem_last, done;
  logic [EW-1:0] elem_index;
  logic [2:0]    op_alu;
  logic [1:0]    op_mem, op_wb;
  logic [4:0]    op_d;
`ifdef VECTOR_MASK_EN
  logic [VS-1:0] v0_mask;
  logic          elem_we;
`endif

  vector_element_sequencer #(.VECTOR_SIZE(VS), .ENTRY_INDEX_SIZE(EW)) dut (
    .clk(clk), .rst_n(rst_n), .chip_enabled(chip_enabled),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .is_vector_instruction(is_vector_instruction), .vl(vl),
    .alu_signal(alu_signal), .mem_vis_signal(mem_vis_signal),
    .wb_signal(wb_signal), .d_index(d_index),
    .elem_ready(elem_ready), .mem_done(mem_done),
    .elem_valid(elem_valid), .elem_index(elem_index), .elem_last(elem_last),
    .op_alu(op_alu), .op_mem(op_mem), .op_wb(op_wb), .op_d(op_d),
`ifdef VECTOR_MASK_EN
    .v0_mask(v0_mask), .elem_we(elem_we),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected per-cycle view of one instruction, built from the element/latency schedule.
  typedef struct {
    bit ce; bit valid; bit last; bit we; bit done; bit rdy;
    bit ereq; bit mdone; int idx;
  } cyc_t;
  cyc_t tl[$];

  int cfg_stall[VS];
  int cfg_lat[VS];
  int cfg_fz_elem, cfg_fz_len, cfg_fz_pct;

  task automatic clear_cfg();
    for (int k = 0; k < VS; k++) begin cfg_stall[k] = 0; cfg_lat[k] = 1; end
    cfg_fz_elem = -1; cfg_fz_len = 0; cfg_fz_pct = 0;
  endtask

  task automatic emit(bit valid, bit last, bit we, bit dn, int idx, bit ereq, bit mdone, int fz_len);
    cyc_t c;
    int len = fz_len;
    if (len == 0 && int'($urandom_range(99)) < cfg_fz_pct) len = int'($urandom_range(3, 1));
    for (int i = 0; i < len; i++) begin
      c.ce = 0; c.valid = 0; c.last = 0; c.we = 0; c.done = 0; c.rdy = 0;
      c.ereq = 1'($urandom_range(1)); c.mdone = 1'($urandom_range(1)); c.idx = idx;
      tl.push_back(c);
    end
    c.ce = 1; c.valid = valid; c.last = last; c.we = we; c.done = dn; c.rdy = 0;
    c.ereq = ereq; c.mdone = mdone; c.idx = idx;
    tl.push_back(c);
  endtask

  task automatic run_instr(bit is_vec, int vlv, logic [2:0] alu, logic [1:0] mem,
                           logic [1:0] wb, logic [4:0] d, logic [VS-1:0] mask);
    int n;
    logic [VS-1:0] eff_mask;
    cyc_t c;
`ifdef VECTOR_MASK_EN
    eff_mask = mask;
`else
    eff_mask = '1;
`endif
    n = is_vec ? ((vlv > VS) ? VS : vlv) : 1;
    tl.delete();
    c.ce = 1; c.valid = 0; c.last = 0; c.we = 0; c.done = 0; c.rdy = 1;
    c.ereq = 1'($urandom_range(1)); c.mdone = 1'($urandom_range(1)); c.idx = -1;
    tl.push_back(c);
    for (int k = 0; k < n; k++) begin
      bit we = is_vec ? eff_mask[k] : 1'b1;
      for (int s = 0; s <= cfg_stall[k]; s++)
        emit(1, k == n - 1, we, 0, k, s == cfg_stall[k], 1'($urandom_range(1)),
             (k == cfg_fz_elem && s == 0) ? cfg_fz_len : 0);
      if (mem != 2'd0 && we)
        for (int w = 1; w <= cfg_lat[k]; w++)
          emit(0, 0, 0, 0, k, 1'($urandom_range(1)), w == cfg_lat[k], 0);
    end
    emit(0, 0, 0, 1, (n == 0) ? 0 : n - 1, 1'($urandom_range(1)), 1'($urandom_range(1)), 0);

    foreach (tl[i]) begin
      chip_enabled = tl[i].ce;
      elem_ready   = tl[i].ereq;
      mem_done     = tl[i].mdone;
      if (i == 0) begin
        issue_valid = 1; is_vector_instruction = is_vec; vl = (EW+1)'(vlv);
        alu_signal = alu; mem_vis_signal = mem; wb_signal = wb; d_index = d;
`ifdef VECTOR_MASK_EN
        v0_mask = mask;
`endif
      end else begin
        issue_valid = 1'($urandom_range(1)); is_vector_instruction = 1'($urandom_range(1));
        vl = (EW+1)'($urandom); alu_signal = 3'($urandom); mem_vis_signal = 2'($urandom);
        wb_signal = 2'($urandom); d_index = 5'($urandom);
`ifdef VECTOR_MASK_EN
        v0_mask = VS'($urandom);
`endif
      end
      @(negedge clk);
      checks++;
      if (elem_valid !== tl[i].valid) begin
        errors++; $display("FAIL elem_valid cyc %0d got %b exp %b", i, elem_valid, tl[i].valid);
      end
      checks++;
      if (done !== tl[i].done) begin
        errors++; $display("FAIL done cyc %0d got %b exp %b", i, done, tl[i].done);
      end
      checks++;
      if (issue_ready !== tl[i].rdy) begin
        errors++; $display("FAIL issue_ready cyc %0d got %b exp %b", i, issue_ready, tl[i].rdy);
      end
      if (tl[i].idx >= 0) begin
        checks++;
        if (elem_index !== EW'(tl[i].idx)) begin
          errors++; $display("FAIL elem_index cyc %0d got %0d exp %0d", i, elem_index, tl[i].idx);
        end
      end
      if (tl[i].valid) begin
        checks++;
        if (elem_last !== tl[i].last) begin
          errors++; $display("FAIL elem_last cyc %0d got %b exp %b", i, elem_last, tl[i].last);
        end
`ifdef VECTOR_MASK_EN
        checks++;
        if (elem_we !== tl[i].we) begin
          errors++; $display("FAIL elem_we cyc %0d got %b exp %b", i, elem_we, tl[i].we);
        end
`endif
      end
      if (i > 0) begin
        checks++;
        if ({op_alu, op_mem, op_wb, op_d} !== {alu, mem, wb, d}) begin
          errors++;
          $display("FAIL op_fields cyc %0d got %h/%h/%h/%h exp %h/%h/%h/%h",
                   i, op_alu, op_mem, op_wb, op_d, alu, mem, wb, d);
        end
      end
      @(posedge clk); #1;
    end
    issue_valid = 0;
  endtask

  task automatic check_idle(string tag);
    checks++;
    if ({elem_valid, done, elem_last, issue_ready, elem_index, op_alu, op_mem, op_wb, op_d} !==
        {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 2'd0, 2'd0, 5'd0}) begin
      errors++;
      $display("FAIL %s got v%b d%b l%b r%b i%0d ops %h/%h/%h/%h exp v0 d0 l0 r1 i0 ops 0",
               tag, elem_valid, done, elem_last, issue_ready, elem_index, op_alu, op_mem, op_wb, op_d);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; chip_enabled = 1; issue_valid = 0; is_vector_instruction = 0; vl = '0;
    alu_signal = '0; mem_vis_signal = '0; wb_signal = '0; d_index = '0;
    elem_ready = 0; mem_done = 0;
`ifdef VECTOR_MASK_EN
    v0_mask = '0;
`endif
    repeat (2) @(posedge clk);
    #1; @(negedge clk);
    check_idle("reset_state");
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    chip_enabled = 1; elem_ready = 1; mem_done = 0;
    issue_valid = 1; is_vector_instruction = 1; vl = 4'd8;
    alu_signal = 3'd5; mem_vis_signal = 2'd0; wb_signal = 2'd2; d_index = 5'd17;
    @(posedge clk); #1;
    issue_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (elem_index !== EW'(k) || elem_valid !== 1'b1) begin
        errors++; $display("FAIL reset_mid_pre idx got %0d/%b exp %0d/1", elem_index, elem_valid, k);
      end
      if (k == 3) rst_n = 0;
      @(posedge clk); #1;
    end
    rst_n = 1;
    @(negedge clk);
    check_idle("reset_mid_after");
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1; @(negedge clk);
      checks++;
      if (done !== 1'b0 || issue_ready !== 1'b1) begin
        errors++; $display("FAIL reset_mid_nodone got done=%b rdy=%b exp done=0 rdy=1", done, issue_ready);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_vector_alu();
    clear_cfg();
    run_instr(1, 5, 3'd3, 2'd0, 2'd1, 5'd9, '1);
  endtask

  task automatic test_vl_bounds();
    clear_cfg();
    run_instr(1, 12, 3'd1, 2'd0, 2'd1, 5'd4, '1);
    run_instr(1, 0, 3'd6, 2'd0, 2'd3, 5'd30, '1);
    run_instr(1, 8, 3'd2, 2'd0, 2'd2, 5'd1, '1);
  endtask

  task automatic test_vector_load();
    clear_cfg();
    for (int k = 0; k < VS; k++) cfg_lat[k] = 2;
    run_instr(1, 3, 3'd0, 2'd1, 2'd1, 5'd12, '1);
  endtask

  task automatic test_scalar_stall();
    clear_cfg();
    cfg_stall[0] = 4;
    run_instr(0, 6, 3'd7, 2'd0, 2'd2, 5'd3, '1);
  endtask

  task automatic test_freeze();
    clear_cfg();
    cfg_fz_elem = 2; cfg_fz_len = 3;
    run_instr(1, 6, 3'd4, 2'd0, 2'd1, 5'd22, '1);
  endtask

  task automatic test_mask();
    clear_cfg();
    run_instr(1, 4, 3'd2, 2'd0, 2'd1, 5'd5, 8'b0000_0101);
    for (int k = 0; k < VS; k++) cfg_lat[k] = 2;
    run_instr(1, 4, 3'd2, 2'd2, 2'd1, 5'd6, 8'b0000_0101);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      clear_cfg();
      for (int k = 0; k < VS; k++) begin
        cfg_stall[k] = int'($urandom_range(2));
        cfg_lat[k]   = int'($urandom_range(3, 1));
      end
      cfg_fz_pct = 10;
      run_instr(($urandom_range(9) < 8), int'($urandom_range(15)), 3'($urandom),
                ($urandom_range(1) == 1) ? 2'($urandom_range(3, 1)) : 2'd0,
                2'($urandom), 5'($urandom), VS'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_vector_alu();
    test_vl_bounds();
    test_vector_load();
    test_scalar_stall();
    test_freeze();
    test_mask();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
